wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//   Write-side initiator for the 32x32 general register file. Collects writeback results
//   from two producers: A = ALU/EX path, B = load/multi-cycle unit.
//   Queues them in an in-order FIFO and drives exactly one regfile write per cycle.
//   Provides two lookup ports so decode can forward values that are still pending in the queue.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, >= 2
//   AW     5   register address width
//   DW     32  register data width
// PORTS
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      asynchronous active-low reset (0 = reset)
//   a_valid  in   1      producer A has a result
//   a_ready  out  1      A accepted this cycle when a_valid & a_ready
//   a_addr   in   AW     A destination register
//   a_data   in   DW     A result
//   b_valid  in   1      producer B has a result
//   b_ready  out  1      B accepted this cycle when b_valid & b_ready
//   b_addr   in   AW     B destination register
//   b_data   in   DW     B result
//   we       out  1      regfile write enable (head entry valid)
//   waddr    out  AW     regfile write address
//   wdata    out  DW     regfile write data
//   q_raddr1 in   AW     lookup address, decode read port 1
//   q_hit1   out  1      pending entry matches q_raddr1
//   q_data1  out  DW     data of youngest matching entry, else 0
//   q_raddr2 in   AW     lookup address, decode read port 2
//   q_hit2   out  1      as q_hit1, for port 2
//   q_data2  out  DW     as q_data1, for port 2
//   empty    out  1      no pending writes (used to drain before exception entry)
// BEHAVIOUR
// - Reset (rst=0, async): rd/wr pointers=0, count=0.
//   Outputs: we=0, waddr=0, wdata=0, q_hit*=0, q_data*=0, empty=1.
//   Queue contents are don't-care. Reset mid-operation discards all pending entries.
// - Storage: circular buffer, pointers wrap modulo DEPTH, count width $clog2(DEPTH)+1.
// - Drain: we/waddr/wdata are combinational from the head entry. we=1 iff count!=0.
//   The head is popped on every rising edge where count!=0; there is no stall input.
//   When empty, waddr=0 and wdata=0.
// - Latency: a result accepted at edge N drives we=1 in cycle N+1 at the earliest,
//   one cycle per older entry later.
// - Space: free = DEPTH - count + (count!=0 ? 1 : 0); the pop is credited in the same cycle.
//   a_ready = (free >= 1).
//   b_ready = (free >= 2) when a_valid, else (free >= 1). A has priority.
// - Simultaneous accept of A and B: A is written at wr_ptr, B at wr_ptr+1, so A is older.
//   count += 2 minus pop.
// - Register 0: a write addressed to r0 is handshaken (ready=1 when space allows)
//   but never stored. It consumes no slot and never asserts we.
//   When both A and B target r0, both are dropped.
// - Lookup: combinational scan of valid entries.
//   q_hitN=1 iff some entry addr==q_raddrN and q_raddrN!=0.
//   q_dataN = data of the youngest such entry (nearest to wr_ptr).
//   The current head entry is included in the scan even though it is being written this cycle.
//   Same-cycle incoming a_/b_ data is NOT visible through lookup.
// - Same register queued twice: both writes reach the regfile in order, so the final value
//   is the younger one. Lookup returns the younger entry.
// - Full (count=DEPTH): the head still pops, so free=1. A alone is accepted; B with A valid
//   is refused. The queue never overflows or underflows.
// - a_ready/b_ready depend only on count and a_valid, never on b_valid (no comb loop from B).
// TESTING
// 1 Reset, then A writes r3=0x11 at edge 1 -> cycle 2: we=1, waddr=3, wdata=0x11;
//   cycle 3: we=0, empty=1.
// 2 Same edge: A r5=0xA, B r6=0xB -> both ready. Regfile writes r5 then r6 in consecutive
//   cycles. Lookup of r6 hits with 0xB until the r6 write cycle ends.
// 3 A r0=0xFF and B r0=0x1 together -> both accepted, count stays 0, we never asserts,
//   q_hit for r0 stays 0.
// 4 Queue at count=DEPTH with A and B valid -> a_ready=1, b_ready=0.
//   Next cycle count stays DEPTH; B is accepted once free>=2.
// 5 Queue r7=1 then r7=2 -> q_data for r7 = 2. After both drain, q_hit=0 and the regfile holds 2.
// 6 Assert rst=0 asynchronously mid-burst with 3 entries pending -> we drops to 0 immediately,
//   empty=1, no pending write reaches the regfile after release.

Source files
------------

// File: rtl/wb_write_queue.sv
// In-order writeback queue: merges producers A (priority) and B into one regfile write per cycle.
// Accepted entry writes the regfile one cycle later at the earliest; ready is driven from count and a_valid only.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] q_raddr1,
  output logic          q_hit1,
  output logic [DW-1:0] q_data1,
  input  logic [AW-1:0] q_raddr2,
  output logic          q_hit2,
  output logic [DW-1:0] q_data2,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          pop;
  logic          a_push;
  logic          b_push;
  logic [PW-1:0] b_slot;

  // The head leaves on every edge while non-empty, so its slot is already free.
  assign pop     = (count != '0);
  assign free    = CW'(DEPTH) - count + CW'(pop);
  assign a_ready = (free >= CW'(1));
  assign b_ready = a_valid ? (free >= CW'(2)) : (free >= CW'(1));

  // r0 writes complete the handshake but are never stored.
  assign a_push = a_valid & a_ready & (a_addr != '0);
  assign b_push = b_valid & b_ready & (b_addr != '0);
  assign b_slot = wr_ptr + PW'(a_push);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(a_push) + PW'(b_push);
      count  <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) mem[wr_ptr] <= '{addr: a_addr, data: a_data};
    if (b_push) mem[b_slot] <= '{addr: b_addr, data: b_data};
  end

  assign we    = pop;
  assign waddr = pop ? mem[rd_ptr].addr : '0;
  assign wdata = pop ? mem[rd_ptr].data : '0;
  assign empty = !pop;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = rd_ptr;
    q_hit1  = 1'b0;
    q_data1 = '0;
    q_hit2  = 1'b0;
    q_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (q_raddr1 != '0 && mem[idx].addr == q_raddr1) begin
          q_hit1  = 1'b1;
          q_data1 = mem[idx].data;
        end
        if (q_raddr2 != '0 && mem[idx].addr == q_raddr2) begin
          q_hit2  = 1'b1;
          q_data2 = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios then random traffic against a queue-based model;
// a separate monitor pops expected regfile writes whenever we is high.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q_raddr1 = '0, q_raddr2 = '0;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        mq[$];     // entries the DUT should hold right now
  ent_t        exp_q[$];  // expected regfile writes, in order
  logic [31:0] rf_ref [32];
  logic [31:0] rf_dut [32];

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_raddr1(q_raddr1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_raddr2(q_raddr2), .q_hit2(q_hit2), .q_data2(q_data2),
    .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write to ra wins; r0 never hits.
  task automatic model_lookup(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != 0)
      foreach (mq[i])
        if (mq[i].addr == ra) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    int          free;
    logic        ear, ebr, h;
    logic [31:0] d;
    ent_t        e;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    q_raddr1 = r1; q_raddr2 = r2;
    #1;
    free = DEPTH - mq.size() + ((mq.size() != 0) ? 1 : 0);
    ear  = (free >= 1);
    ebr  = av ? (free >= 2) : (free >= 1);
    chk("a_ready", a_ready, ear);
    chk("b_ready", b_ready, ebr);
    chk("empty", empty, mq.size() == 0);
    chk("we", we, mq.size() != 0);
    model_lookup(r1, h, d);
    chk("q_hit1", q_hit1, h);
    chk("q_data1", q_data1, d);
    model_lookup(r2, h, d);
    chk("q_hit2", q_hit2, h);
    chk("q_data2", q_data2, d);
    @(posedge clk);
    if (mq.size() != 0) begin
      e = mq.pop_front();
      rf_ref[e.addr] = e.data;
    end
    if (av && ear && aa != 0) begin
      mq.push_back({aa, ad});
      exp_q.push_back({aa, ad});
    end
    if (bv && ebr && ba != 0) begin
      mq.push_back({ba, bd});
      exp_q.push_back({ba, bd});
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Monitor: every cycle with we high must match the oldest expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t", waddr, wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", waddr, e.addr);
          chk("wdata", wdata, e.data);
          rf_dut[waddr] = wdata;
        end
      end else begin
        chk("idle_waddr", waddr, 0);
        chk("idle_wdata", wdata, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_ref[i] = '0;
      rf_dut[i] = '0;
    end
    q_raddr1 = 5'd3;
    #2;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_q_hit1", q_hit1, 0);
    chk("rst_q_data1", q_data1, 0);
    #20;
    rst = 1'b1;

    // Single A write, then drain.
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd0);

    // A and B in the same cycle; lookup r6 until its write ends.
    step(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, 5'd6, 5'd5);
    idle(5'd6, 5'd5);
    idle(5'd6, 5'd5);
    idle(5'd6, 5'd5);

    // Both producers target r0.
    step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'h1, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Fill to DEPTH, then hold A+B pressure at full.
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(8 + 2 * i), 32'h100 + i, 1'b1, 5'(9 + 2 * i), 32'h200 + i, 5'd9, 5'd10);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h300, 5'd20, 5'd9);
    for (int i = 0; i < DEPTH + 1; i++) idle(5'd20, 5'd11);

    // Same register queued twice: younger value wins.
    step(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    step(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(5'd7, 5'd7);
    idle(5'd7, 5'd7);
    idle(5'd7, 5'd7);
    chk("r7_final", rf_dut[7], 32'd2);

    // Asynchronous reset with 3 entries pending.
    step(1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hC2, 5'd12, 5'd13);
    step(1'b1, 5'd14, 32'hC3, 1'b1, 5'd15, 32'hC4, 5'd14, 5'd15);
    chk("pre_rst_pending", mq.size(), 3);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_empty", empty, 1);
    mq.delete();
    exp_q.delete();
    idle(5'd14, 5'd15);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(5'd14, 5'd15);

    // Random traffic over a small register set to provoke collisions and r0.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) idle(5'd1, 5'd2);
    idle(5'd1, 5'd2);
    chk("drain_expq", exp_q.size(), 0);
    for (int i = 1; i < 32; i++) chk($sformatf("rf_r%0d", i), rf_dut[i], rf_ref[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
